// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction-fetch sequencer for the MIPS core.
// Owns the PC, addresses a combinational instruction ROM, captures the word into an
// IF/ID register handed to decode over valid/ready, and applies branch/jump redirects.
// Optional macro IFETCH_PERF_EN adds FetchCount/FlushCount performance counters.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Halt,
    output logic [31:0] Addr,
    input  logic [31:0] INST,
    output logic [31:0] InstOut,
    output logic [31:0] PCOut,
    output logic        Valid,
    input  logic        Ready,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [1:0]  State
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StHalted = 2'b10
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_fire;

    // Redirect select: branch is older than jump, so it wins; targets are word aligned.
    always_comb begin
        w_redirect = BranchTaken | Jump;
        w_target   = BranchTaken ? BranchTarget : JumpTarget;
        w_target   = {w_target[31:2], 2'b00};
        w_fire     = (r_state == StRun) && !Halt && (!r_valid || Ready) && !w_redirect;
    end

    // Run/halt state register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; IDLE is left only once and re-entered only through reset.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (Run && !Halt) w_state_next = StRun;
            StRun:    if (Halt) w_state_next = StHalted;
            StHalted: if (Run && !Halt) w_state_next = StRun;
            default:  w_state_next = StIdle;
        endcase
    end

    // PC and IF/ID register: redirect squashes, else fetch, else drain on consume.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc     <= RESET_PC;
            r_inst   <= 32'h0;
            r_pc_out <= 32'h0;
            r_valid  <= 1'b0;
        end else if (w_redirect) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_inst   <= INST;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + 32'd4;
        end else if (r_valid && Ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fetch_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (w_fire) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_redirect) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign FetchCount = r_fetch_cnt;
    assign FlushCount = r_flush_cnt;
`endif

    assign Addr    = r_pc;
    assign InstOut = r_inst;
    assign PCOut   = r_pc_out;
    assign Valid   = r_valid;
    assign State   = r_state;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed bench for inst_fetch_ctrl with a behavioural ROM.
// ROM word for address A is 32'hC0DE_0000 | A[9:2]. Build with IFETCH_PERF_EN for counters.
module tb_inst_fetch_ctrl;

    logic        CLK;
    logic        Reset_n;
    logic        Run;
    logic        Halt;
    logic [31:0] Addr;
    logic [31:0] INST;
    logic [31:0] InstOut;
    logic [31:0] PCOut;
    logic        Valid;
    logic        Ready;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [1:0]  State;
`ifdef IFETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .CLK          (CLK),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .Halt         (Halt),
        .Addr         (Addr),
        .INST         (INST),
        .InstOut      (InstOut),
        .PCOut        (PCOut),
        .Valid        (Valid),
        .Ready        (Ready),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .State        (State)
`ifdef IFETCH_PERF_EN
        ,
        .FetchCount   (FetchCount),
        .FlushCount   (FlushCount)
`endif
    );

    // Combinational ROM model.
    assign INST = 32'hC0DE_0000 | {24'h0, Addr[9:2]};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, need finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_io(input string tag, input logic [1:0] st, input logic vld,
                            input logic [31:0] adr);
        check_eq({tag, ".state"}, {30'h0, State}, {30'h0, st});
        check_eq({tag, ".valid"}, {31'h0, Valid}, {31'h0, vld});
        check_eq({tag, ".addr"}, Addr, adr);
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc);
        check_eq({tag, ".pcout"}, PCOut, pc);
        check_eq({tag, ".inst"}, InstOut, 32'hC0DE_0000 | {24'h0, pc[9:2]});
    endtask

    initial begin
        Reset_n      = 1'b0;
        Run          = 1'b0;
        Halt         = 1'b0;
        Ready        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        Jump         = 1'b0;
        JumpTarget   = 32'h0;
        #12;
        check_io("reset", 2'b00, 1'b0, 32'h0);
        check_eq("reset.inst", InstOut, 32'h0);
        check_eq("reset.pcout", PCOut, 32'h0);
        Reset_n = 1'b1;
        tick();
        check_io("idle_hold", 2'b00, 1'b0, 32'h0);

        // Start streaming.
        Run   = 1'b1;
        Ready = 1'b1;
        tick();
        check_io("enter_run", 2'b01, 1'b0, 32'h0);
        tick();
        check_io("fetch0", 2'b01, 1'b1, 32'h4);
        check_out("fetch0", 32'h0);
        tick();
        check_io("fetch1", 2'b01, 1'b1, 32'h8);
        check_out("fetch1", 32'h4);
        tick();
        check_io("fetch2", 2'b01, 1'b1, 32'hC);
        check_out("fetch2", 32'h8);

        // Back-pressure for three cycles.
        Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_io("stall", 2'b01, 1'b1, 32'hC);
            check_out("stall", 32'h8);
        end
        Ready = 1'b1;
        tick();
        check_io("resume", 2'b01, 1'b1, 32'h10);
        check_out("resume", 32'hC);

        // Simultaneous branch and jump: branch wins.
        BranchTaken  = 1'b1;
        BranchTarget = 32'h40;
        Jump         = 1'b1;
        JumpTarget   = 32'h80;
        tick();
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        check_io("redir", 2'b01, 1'b0, 32'h40);
`ifdef IFETCH_PERF_EN
        check_eq("redir.flushcnt", FlushCount, 32'd1);
        check_eq("redir.fetchcnt", FetchCount, 32'd4);
`endif
        tick();
        check_io("redir_tgt", 2'b01, 1'b1, 32'h44);
        check_out("redir_tgt", 32'h40);

        // Unaligned jump target is forced to word alignment.
        Jump       = 1'b1;
        JumpTarget = 32'h23;
        tick();
        Jump = 1'b0;
        check_io("jump", 2'b01, 1'b0, 32'h20);
        tick();
        check_io("jump_tgt", 2'b01, 1'b1, 32'h24);
        check_out("jump_tgt", 32'h20);

        // Halt while holding a word.
        Ready = 1'b0;
        Halt  = 1'b1;
        tick();
        check_io("halt_hold", 2'b10, 1'b1, 32'h24);
        check_out("halt_hold", 32'h20);
        Ready = 1'b1;
        tick();
        check_io("halt_drain", 2'b10, 1'b0, 32'h24);
        tick();
        check_io("halt_idle", 2'b10, 1'b0, 32'h24);
        Halt = 1'b0;
        tick();
        check_io("rerun", 2'b01, 1'b0, 32'h24);
        tick();
        check_io("rerun_fetch", 2'b01, 1'b1, 32'h28);
        check_out("rerun_fetch", 32'h24);

        // PC wrap at the top of the address space.
        Jump       = 1'b1;
        JumpTarget = 32'hFFFF_FFFC;
        tick();
        Jump = 1'b0;
        check_io("wrap_redir", 2'b01, 1'b0, 32'hFFFF_FFFC);
        tick();
        check_io("wrap", 2'b01, 1'b1, 32'h0);
        check_out("wrap", 32'hFFFF_FFFC);
`ifdef IFETCH_PERF_EN
        check_eq("wrap.fetchcnt", FetchCount, 32'd8);
        check_eq("wrap.flushcnt", FlushCount, 32'd3);
`endif

        // Asynchronous reset between edges.
        #2;
        Reset_n = 1'b0;
        #1;
        check_io("async_rst", 2'b00, 1'b0, 32'h0);
        check_eq("async_rst.pcout", PCOut, 32'h0);
        check_eq("async_rst.inst", InstOut, 32'h0);
`ifdef IFETCH_PERF_EN
        check_eq("async_rst.fetchcnt", FetchCount, 32'd0);
        check_eq("async_rst.flushcnt", FlushCount, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
